// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request arbiter: command codes, snoop results,
// source IDs, FSM state encoding and the per-source command legality check.
package l2_pkg;

  localparam logic [3:0] CMD_RD   = 4'd0;
  localparam logic [3:0] CMD_WR   = 4'd1;
  localparam logic [3:0] CMD_IRD  = 4'd2;
  localparam logic [3:0] CMD_SINV = 4'd3;
  localparam logic [3:0] CMD_SRD  = 4'd4;
  localparam logic [3:0] CMD_SWR  = 4'd5;
  localparam logic [3:0] CMD_SRFO = 4'd6;
  localparam logic [3:0] CMD_CLR  = 4'd8;
  localparam logic [3:0] CMD_PRT  = 4'd9;

  localparam logic [1:0] SNP_HIT   = 2'd0;
  localparam logic [1:0] SNP_NOHIT = 2'd1;
  localparam logic [1:0] SNP_HITM  = 2'd2;

  localparam logic [1:0] SRC_L1D = 2'd0;
  localparam logic [1:0] SRC_L1I = 2'd1;
  localparam logic [1:0] SRC_SNP = 2'd2;
  localparam logic [1:0] SRC_MNT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // L1I carries an implied command, so it can never be illegal.
  function automatic logic cmd_legal(input logic [1:0] src, input logic [3:0] cmd);
    case (src)
      SRC_L1D: cmd_legal = (cmd == CMD_RD) || (cmd == CMD_WR);
      SRC_L1I: cmd_legal = 1'b1;
      SRC_SNP: cmd_legal = (cmd >= CMD_SINV) && (cmd <= CMD_SRFO);
      default: cmd_legal = (cmd == CMD_CLR) || (cmd == CMD_PRT);
    endcase
  endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational grant selection: SNP > L1 (round-robin) > MNT, with the snoop
// burst guard forcing an L1 grant once the burst limit is reached.
module l2_arb_pick
  import l2_pkg::*;
#(
  parameter int SNP_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic [3:0]       i_valid,
  input  logic             i_ptr,
  input  logic [CNT_W-1:0] i_snp_cnt,
  output logic [3:0]       o_grant
);

  logic w_l1_any;
  logic w_l1_force;

  assign w_l1_any   = i_valid[SRC_L1D] | i_valid[SRC_L1I];
  assign w_l1_force = w_l1_any && (i_snp_cnt >= CNT_W'(SNP_BURST));

  // i_ptr low prefers L1D when both L1 sources request.
  always_comb begin
    o_grant = 4'b0000;
    if (i_valid[SRC_SNP] && !w_l1_force) begin
      o_grant[SRC_SNP] = 1'b1;
    end else if (w_l1_any) begin
      if (i_valid[SRC_L1D] && (!i_valid[SRC_L1I] || !i_ptr))
        o_grant[SRC_L1D] = 1'b1;
      else
        o_grant[SRC_L1I] = 1'b1;
    end else if (i_valid[SRC_MNT]) begin
      o_grant[SRC_MNT] = 1'b1;
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Single-issue L2 front end: accepts one request, issues it, waits for c_done.
// Optional grant counters are built when L2_ARB_STATS_EN is defined.
module l2_req_arbiter
  import l2_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int SNP_BURST = 4,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l1d_valid,
  output logic              l1d_ready,
  input  logic [3:0]        l1d_cmd,
  input  logic [ADDR_W-1:0] l1d_addr,
  input  logic              l1i_valid,
  output logic              l1i_ready,
  input  logic [ADDR_W-1:0] l1i_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [3:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  input  logic              mnt_valid,
  output logic              mnt_ready,
  input  logic [3:0]        mnt_cmd,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [3:0]        c_cmd,
  output logic [ADDR_W-1:0] c_addr,
  output logic [1:0]        c_src,
  input  logic              c_done,
  input  logic [1:0]        c_snp_res,
  output logic              l1d_done,
  output logic              l1i_done,
  output logic              snp_res_valid,
  output logic [1:0]        snp_res,
  output logic              cmd_err,
  output logic              busy
`ifdef L2_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_l1d,
  output logic [STAT_W-1:0] stat_l1i,
  output logic [STAT_W-1:0] stat_snp,
  output logic [STAT_W-1:0] stat_mnt
`endif
);

  localparam int CNT_W = $clog2(SNP_BURST + 1);

  state_e            r_state, w_state_nxt;
  logic              r_ptr;
  logic [CNT_W-1:0]  r_snp_cnt;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_src;
  logic              r_l1d_done, r_l1i_done, r_snp_res_valid, r_cmd_err;
  logic [1:0]        r_snp_res;

  logic [3:0]        w_valid, w_pick, w_gnt;
  logic [3:0]        w_acc_cmd;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [1:0]        w_acc_src;
  logic              w_idle, w_acc, w_legal, w_fin, w_l1_pend;

  assign w_valid = {mnt_valid, snp_valid, l1i_valid, l1d_valid};

  l2_arb_pick #(.SNP_BURST(SNP_BURST), .CNT_W(CNT_W)) u_pick (
    .i_valid   (w_valid),
    .i_ptr     (r_ptr),
    .i_snp_cnt (r_snp_cnt),
    .o_grant   (w_pick)
  );

  // Readies must stay low while reset is held even though the state reads IDLE.
  assign w_idle    = (r_state == ST_IDLE) && !rst;
  assign w_gnt     = w_idle ? w_pick : 4'b0000;
  assign l1d_ready = w_gnt[SRC_L1D];
  assign l1i_ready = w_gnt[SRC_L1I];
  assign snp_ready = w_gnt[SRC_SNP];
  assign mnt_ready = w_gnt[SRC_MNT];
  assign w_acc     = |w_gnt;
  assign w_fin     = (r_state == ST_WAIT) && c_done;
  assign w_l1_pend = l1d_valid | l1i_valid;

  always_comb begin
    w_acc_src  = SRC_MNT;
    w_acc_cmd  = mnt_cmd;
    w_acc_addr = '0;
    if (w_gnt[SRC_L1D]) begin
      w_acc_src  = SRC_L1D;
      w_acc_cmd  = l1d_cmd;
      w_acc_addr = l1d_addr;
    end else if (w_gnt[SRC_L1I]) begin
      w_acc_src  = SRC_L1I;
      w_acc_cmd  = CMD_IRD;
      w_acc_addr = l1i_addr;
    end else if (w_gnt[SRC_SNP]) begin
      w_acc_src  = SRC_SNP;
      w_acc_cmd  = snp_cmd;
      w_acc_addr = snp_addr;
    end
  end

  assign w_legal = cmd_legal(w_acc_src, w_acc_cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    c_valid     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_acc && w_legal) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        c_valid = 1'b1;
        if (c_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (c_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr           <= 1'b0;
      r_snp_cnt       <= '0;
      r_cmd           <= '0;
      r_addr          <= '0;
      r_src           <= '0;
      r_l1d_done      <= 1'b0;
      r_l1i_done      <= 1'b0;
      r_snp_res_valid <= 1'b0;
      r_snp_res       <= '0;
      r_cmd_err       <= 1'b0;
    end else begin
      r_cmd_err       <= w_acc && !w_legal;
      r_l1d_done      <= w_fin && (r_src == SRC_L1D);
      r_l1i_done      <= w_fin && (r_src == SRC_L1I);
      r_snp_res_valid <= w_fin && (r_src == SRC_SNP);
      if (w_fin && (r_src == SRC_SNP)) r_snp_res <= c_snp_res;
      if (w_acc && w_legal) begin
        r_cmd  <= w_acc_cmd;
        r_addr <= w_acc_addr;
        r_src  <= w_acc_src;
      end
      if (w_gnt[SRC_L1D]) r_ptr <= 1'b1;
      if (w_gnt[SRC_L1I]) r_ptr <= 1'b0;
      if (!w_l1_pend || w_gnt[SRC_L1D] || w_gnt[SRC_L1I])
        r_snp_cnt <= '0;
      else if (w_gnt[SRC_SNP] && (r_snp_cnt != CNT_W'(SNP_BURST)))
        r_snp_cnt <= r_snp_cnt + CNT_W'(1);
    end
  end

  assign c_cmd         = r_cmd;
  assign c_addr        = r_addr;
  assign c_src         = r_src;
  assign l1d_done      = r_l1d_done;
  assign l1i_done      = r_l1i_done;
  assign snp_res_valid = r_snp_res_valid;
  assign snp_res       = r_snp_res;
  assign cmd_err       = r_cmd_err;

`ifdef L2_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [4];
  logic              w_clr;

  assign w_clr = w_fin && (r_src == SRC_MNT) && (r_cmd == CMD_CLR);

  // Every accepted request counts, including ones dropped as illegal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_gnt[i] && (r_stat[i] != {STAT_W{1'b1}}))
          r_stat[i] <= r_stat[i] + STAT_W'(1);
    end
  end

  assign stat_l1d = r_stat[0];
  assign stat_l1i = r_stat[1];
  assign stat_snp = r_stat[2];
  assign stat_mnt = r_stat[3];
`endif

endmodule
